pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter PC_W, default 8, giving the program-counter width in bits.
REQ-002 The block SHALL have parameter RESET_PC, default 0, giving the PC value loaded on reset.
REQ-003 The block SHALL have parameter MAX_WAIT, default 15, giving the maximum number of WAIT cycles before a fetch timeout.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port start, input, 1 bit: begin fetching from IDLE.
REQ-007 The block SHALL have port stall, input, 1 bit: suppress issuing a new fetch.
REQ-008 The block SHALL have port br_taken, input, 1 bit: take a relative branch.
REQ-009 The block SHALL have port br_offset, input, PC_W bits: two's-complement branch offset.
REQ-010 The block SHALL have port jmp_en, input, 1 bit: take an absolute jump.
REQ-011 The block SHALL have port jmp_addr, input, PC_W bits: jump target.
REQ-012 The block SHALL have port halt, input, 1 bit: stop after the current fetch.
REQ-013 The block SHALL have port imem_req, output, 1 bit: instruction-memory request.
REQ-014 The block SHALL have port imem_addr, output, PC_W bits: fetch address, always equal to pc.
REQ-015 The block SHALL have port imem_ack, input, 1 bit: memory accepts the current request.
REQ-016 The block SHALL have port instr_valid, output, 1 bit: registered one-cycle accept pulse.
REQ-017 The block SHALL have port pc, output, PC_W bits: current program counter.
REQ-018 The block SHALL have port state, output, 2 bits: IDLE=0, FETCH=1, WAIT=2, HALTED=3.
REQ-019 The block SHALL have port timeout_err, output, 1 bit: sticky fetch-timeout flag.

Function
REQ-020 The FSM SHALL move from IDLE to FETCH on start=1; otherwise it SHALL stay in IDLE with imem_req=0.
REQ-021 In FETCH with stall=1, the block SHALL drive imem_req=0, hold pc, and remain in FETCH.
REQ-022 In FETCH with stall=0, the block SHALL drive imem_req=1; on imem_ack=1 it SHALL accept and stay in FETCH, otherwise it SHALL go to WAIT.
REQ-023 In WAIT, the block SHALL hold imem_req=1 and imem_addr stable, ignore stall, and return to FETCH on an accept.
REQ-024 An accept SHALL be a rising edge with imem_req=1 and imem_ack=1; imem_ack SHALL be ignored while imem_req=0.
REQ-025 On accept, next pc SHALL be selected by priority halt > jmp_en > br_taken > sequential: hold pc, jmp_addr, pc+br_offset, pc+1.
REQ-026 All PC arithmetic SHALL be modulo 2^PC_W: 255+1 yields 0, and 2+0xFE yields 0.
REQ-027 br_taken, jmp_en and halt SHALL be sampled only on accept edges and ignored otherwise.
REQ-028 An accept with halt=1 SHALL move the FSM to HALTED; HALTED SHALL drive imem_req=0 and SHALL exit only on rst.
REQ-029 instr_valid SHALL be 1 for exactly the one cycle following each accept, including a halting accept.
REQ-030 A wait counter SHALL clear on entry to WAIT and increment each cycle in WAIT without ack.
REQ-031 When the wait counter reaches MAX_WAIT without an ack, the block SHALL set timeout_err=1 and enter HALTED with pc held.
REQ-032 Back-to-back accepts in FETCH SHALL advance pc once per cycle with no bubble.

Reset
REQ-033 While rst=1, the block SHALL immediately force pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, timeout_err=0, and wait counter=0, independent of clk.
REQ-034 Reset asserted in WAIT or HALTED SHALL abort the outstanding request with no accept and no instr_valid.

Verification
REQ-035 Bench SHALL check: start, then imem_ack held 1 for 4 cycles -> pc 0,1,2,3,4, with instr_valid high for 4 cycles.
REQ-036 Bench SHALL check: pc=255 with an accept -> pc=0 (wrap); pc=2, br_taken, br_offset=0xFE -> pc=0.
REQ-037 Bench SHALL check: jmp_en=1, jmp_addr=0x40, and br_taken=1 on the same accept -> pc=0x40.
REQ-038 Bench SHALL check: stall=1 in FETCH for 3 cycles -> imem_req=0 and pc unchanged; ack pulses during stall are ignored.
REQ-039 Bench SHALL check: no ack for MAX_WAIT cycles in WAIT -> timeout_err=1, state=3, pc held; then rst -> pc=0, state=0, timeout_err=0.
REQ-040 Bench SHALL check: halt=1 on an accept at pc=5 -> state=3, pc=5, instr_valid pulses once, imem_req=0 thereafter.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter fetch sequencer with wait timeout and halt
module pc_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_offset,
    input  logic            jmp_en,
    input  logic [PC_W-1:0] jmp_addr,
    input  logic            halt,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc,
    output logic [1:0]      state,
    output logic            timeout_err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        WAIT   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            valid_q, valid_d;
    logic [PC_W-1:0] pc_accept;

    // Target taken on an accept; halting accepts hold pc and are handled below.
    always_comb begin
        pc_accept = pc_q + PC_W'(1);
        if (jmp_en) begin
            pc_accept = jmp_addr;
        end else if (br_taken) begin
            pc_accept = pc_q + br_offset;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        imem_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!stall) begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        valid_d = 1'b1;
                        if (halt) begin
                            state_d = HALTED;
                        end else begin
                            pc_d = pc_accept;
                        end
                    end else begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    valid_d = 1'b1;
                    if (halt) begin
                        state_d = HALTED;
                    end else begin
                        state_d = FETCH;
                        pc_d    = pc_accept;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // This cycle brings the count to MAX_WAIT: give up on the fetch.
                    if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                        err_d   = 1'b1;
                        state_d = HALTED;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign state       = state_q;
    assign timeout_err = err_q;
    assign instr_valid = valid_q;

endmodule
